// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types for the pipelined CPU.
//   word_t    - 32-bit machine word (results, store data, counters)
//   regbits_t - 5-bit register-file index
//   aluop_t   - ALU operation encoding used by the execute stage
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

endpackage

// File: rtl/ex_mem_if.sv
// ex_mem_if: bundle of the signals crossing the EX/MEM pipeline register.
//   Ports  : CLK, nRST (shared clock and active-low reset)
//   Modports:
//     latch - the pipeline register itself (ex_* in, mem_* out)
//     ex    - execute stage, drives ex_* and the pipeline controls
//     mem   - memory stage, consumes mem_*
//     tb    - testbench, drives ex side and observes everything
interface ex_mem_if
    import cpu_types_pkg::*;
(
    input logic CLK,
    input logic nRST
);
    logic     en, flush;
    logic     ex_valid;
    word_t    ex_result;
    logic     ex_zero, ex_negative, ex_overflow, ex_ov_trap;
    word_t    ex_store_data;
    regbits_t ex_rd;
    logic     ex_memren, ex_memwen, ex_regwen, ex_halt;

    logic     mem_valid;
    word_t    mem_result;
    word_t    mem_store_data;
    regbits_t mem_rd;
    logic     mem_zero, mem_negative;
    logic     mem_memren, mem_memwen, mem_regwen;
    logic     mem_exc;
    logic     halted;
    word_t    valid_count;

    modport latch (
        input  CLK, nRST, en, flush, ex_valid, ex_result, ex_zero, ex_negative,
               ex_overflow, ex_ov_trap, ex_store_data, ex_rd, ex_memren,
               ex_memwen, ex_regwen, ex_halt,
        output mem_valid, mem_result, mem_store_data, mem_rd, mem_zero,
               mem_negative, mem_memren, mem_memwen, mem_regwen, mem_exc,
               halted, valid_count
    );

    modport ex (
        input  CLK, nRST, halted,
        output en, flush, ex_valid, ex_result, ex_zero, ex_negative,
               ex_overflow, ex_ov_trap, ex_store_data, ex_rd, ex_memren,
               ex_memwen, ex_regwen, ex_halt
    );

    modport mem (
        input  CLK, nRST, mem_valid, mem_result, mem_store_data, mem_rd,
               mem_zero, mem_negative, mem_memren, mem_memwen, mem_regwen,
               mem_exc, halted, valid_count
    );

    modport tb (
        input  CLK, nRST, mem_valid, mem_result, mem_store_data, mem_rd,
               mem_zero, mem_negative, mem_memren, mem_memwen, mem_regwen,
               mem_exc, halted, valid_count,
        output en, flush, ex_valid, ex_result, ex_zero, ex_negative,
               ex_overflow, ex_ov_trap, ex_store_data, ex_rd, ex_memren,
               ex_memwen, ex_regwen, ex_halt
    );

endinterface

// File: rtl/ex_mem_latch.sv
// ex_mem_latch: EX/MEM pipeline register.
//   Inputs : CLK, nRST (async active-low), en (advance), flush (bubble,
//            beats en), ex_* (execute-stage result, flags, store data,
//            destination register and control bits)
//   Outputs: mem_* (registered copy for the memory stage), mem_exc
//            (overflow trap taken), halted (sticky until reset),
//            valid_count (wrapping count of valid captures)
// Edge priority: halted hold > flush bubble > en capture > hold.
module ex_mem_latch
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     en,
    input  logic     flush,
    input  logic     ex_valid,
    input  word_t    ex_result,
    input  logic     ex_zero,
    input  logic     ex_negative,
    input  logic     ex_overflow,
    input  logic     ex_ov_trap,
    input  word_t    ex_store_data,
    input  regbits_t ex_rd,
    input  logic     ex_memren,
    input  logic     ex_memwen,
    input  logic     ex_regwen,
    input  logic     ex_halt,
    output logic     mem_valid,
    output word_t    mem_result,
    output word_t    mem_store_data,
    output regbits_t mem_rd,
    output logic     mem_zero,
    output logic     mem_negative,
    output logic     mem_memren,
    output logic     mem_memwen,
    output logic     mem_regwen,
    output logic     mem_exc,
    output logic     halted,
    output word_t    valid_count
);

    logic     valid_q, valid_d;
    word_t    result_q, result_d;
    word_t    store_q, store_d;
    regbits_t rd_q, rd_d;
    logic     zero_q, zero_d;
    logic     neg_q, neg_d;
    logic     memren_q, memren_d;
    logic     memwen_q, memwen_d;
    logic     regwen_q, regwen_d;
    logic     exc_q, exc_d;
    logic     halted_q, halted_d;
    word_t    valid_count_q, valid_count_d;

    logic     exc_s;
    logic     commit_s;

    // A trap only counts for a real signed op; a trapped op must not write.
    assign exc_s    = ex_valid & ex_ov_trap & ex_overflow;
    assign commit_s = ex_valid & ~exc_s;

    // Next-state selection: halt freezes everything, then flush, then en.
    always_comb begin
        valid_d       = valid_q;
        result_d      = result_q;
        store_d       = store_q;
        rd_d          = rd_q;
        zero_d        = zero_q;
        neg_d         = neg_q;
        memren_d      = memren_q;
        memwen_d      = memwen_q;
        regwen_d      = regwen_q;
        exc_d         = exc_q;
        halted_d      = halted_q;
        valid_count_d = valid_count_q;
        if (halted_q) begin
            halted_d = 1'b1;
        end else if (flush) begin
            // Bubble: clear everything except the counter.
            valid_d  = 1'b0;
            result_d = 32'h0000_0000;
            store_d  = 32'h0000_0000;
            rd_d     = 5'd0;
            zero_d   = 1'b0;
            neg_d    = 1'b0;
            memren_d = 1'b0;
            memwen_d = 1'b0;
            regwen_d = 1'b0;
            exc_d    = 1'b0;
        end else if (en) begin
            valid_d  = ex_valid;
            result_d = ex_result;
            store_d  = ex_store_data;
            rd_d     = ex_rd;
            zero_d   = ex_zero;
            neg_d    = ex_negative;
            memren_d = ex_memren & commit_s;
            memwen_d = ex_memwen & commit_s;
            regwen_d = ex_regwen & commit_s;
            exc_d    = exc_s;
            halted_d = ex_valid & ex_halt;
            if (ex_valid) begin
                // Trapped and halt instructions are counted too; wraps freely.
                valid_count_d = valid_count_q + 32'd1;
            end else begin
                valid_count_d = valid_count_q;
            end
        end else begin
            halted_d = 1'b0;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q       <= 1'b0;
            result_q      <= 32'h0000_0000;
            store_q       <= 32'h0000_0000;
            rd_q          <= 5'd0;
            zero_q        <= 1'b0;
            neg_q         <= 1'b0;
            memren_q      <= 1'b0;
            memwen_q      <= 1'b0;
            regwen_q      <= 1'b0;
            exc_q         <= 1'b0;
            halted_q      <= 1'b0;
            valid_count_q <= 32'h0000_0000;
        end else begin
            valid_q       <= valid_d;
            result_q      <= result_d;
            store_q       <= store_d;
            rd_q          <= rd_d;
            zero_q        <= zero_d;
            neg_q         <= neg_d;
            memren_q      <= memren_d;
            memwen_q      <= memwen_d;
            regwen_q      <= regwen_d;
            exc_q         <= exc_d;
            halted_q      <= halted_d;
            valid_count_q <= valid_count_d;
        end
    end

    assign mem_valid      = valid_q;
    assign mem_result     = result_q;
    assign mem_store_data = store_q;
    assign mem_rd         = rd_q;
    assign mem_zero       = zero_q;
    assign mem_negative   = neg_q;
    assign mem_memren     = memren_q;
    assign mem_memwen     = memwen_q;
    assign mem_regwen     = regwen_q;
    assign mem_exc        = exc_q;
    assign halted         = halted_q;
    assign valid_count    = valid_count_q;

endmodule
